// File: rtl/spi_slave_top.sv
// SPI target: oversamples CS_N/SCLK/MOSI on the system clock, all four CPOL/CPHA modes,
// one SPI_DATA_WIDTH word per slot, full duplex, MSB first, with a one-entry TX holding buffer.
module spi_slave_top #(
    parameter int SPI_DATA_WIDTH = 8,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_clock_polarity,
    input  logic                      i_clock_phase,
    input  logic [SPI_DATA_WIDTH-1:0] i_tx_data,
    input  logic                      i_tx_valid,
    output logic                      o_tx_ready,
    output logic [SPI_DATA_WIDTH-1:0] o_rx_data,
    output logic                      o_rx_valid,
    output logic                      o_underrun,
    input  logic                      i_spi_cs_n,
    input  logic                      i_spi_clock,
    input  logic                      i_spi_mosi,
    output logic                      o_spi_miso,
    output logic                      o_spi_miso_oe
);
    localparam int W     = SPI_DATA_WIDTH;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   cs_s;
    logic                   sclk_s;
    logic                   mosi_s;

    logic                   cpol_q;
    logic                   cpha_q;
    logic [W-1:0]           tx_buf;
    logic                   tx_full;
    logic [W-1:0]           shift_tx;
    logic [W-1:0]           shift_rx;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   reload_pend;
    logic                   first_shift;

    logic                   in_word;
    logic                   leading_edge;
    logic                   trailing_edge;
    logic                   sample_edge;
    logic                   shift_edge;
    logic                   load_word;
    logic                   tx_write;
    logic                   last_bit;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_spi_clock};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Leading edge leaves the latched idle level, trailing edge returns to it.
    assign in_word       = (state == ACTIVE) && !cs_s;
    assign leading_edge  = cpol_q ? (sclk_d && !sclk_s) : (!sclk_d && sclk_s);
    assign trailing_edge = cpol_q ? (!sclk_d && sclk_s) : (sclk_d && !sclk_s);
    assign sample_edge   = in_word && (cpha_q ? trailing_edge : leading_edge);
    assign shift_edge    = in_word && (cpha_q ? leading_edge : trailing_edge);
    assign load_word     = (state == LOAD) || (shift_edge && reload_pend);
    assign last_bit      = (bit_cnt == CNT_W'(W - 1));

    // TX handshake: a word transfers on any clock edge where i_tx_valid && o_tx_ready;
    // o_tx_ready is simply "holding buffer empty" and never depends on i_tx_valid.
    assign tx_write   = i_tx_valid && o_tx_ready;
    assign o_tx_ready = !tx_full;

    assign o_spi_miso_oe = (state != IDLE);
    assign o_spi_miso    = (state == ACTIVE) && shift_tx[W-1];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!cs_s) state_next = LOAD;
            LOAD:    state_next = cs_s ? IDLE : ACTIVE;
            ACTIVE:  if (cs_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            shift_tx    <= '0;
            shift_rx    <= '0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            first_shift <= 1'b0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
            o_underrun  <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;
            o_underrun <= 1'b0;

            if (state == IDLE) begin
                cpol_q <= i_clock_polarity;
                cpha_q <= i_clock_phase;
            end

            // A write landing with a load from an empty buffer is kept for the next word.
            if (tx_write) begin
                tx_buf <= i_tx_data;
            end
            tx_full <= (tx_full && !load_word) || tx_write;

            if (load_word) begin
                shift_tx   <= tx_full ? tx_buf : '0;
                o_underrun <= !tx_full;
            end else if (shift_edge) begin
                if (!first_shift) begin
                    shift_tx <= {shift_tx[W-2:0], 1'b0};
                end
            end else if (!in_word) begin
                shift_tx <= '0;
            end

            if (state == LOAD) begin
                bit_cnt     <= '0;
                shift_rx    <= '0;
                reload_pend <= 1'b0;
                first_shift <= cpha_q;
            end else if (!in_word) begin
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
                first_shift <= 1'b0;
            end else begin
                // With CPHA=1 the first leading edge only presents the MSB.
                if (shift_edge) begin
                    reload_pend <= 1'b0;
                    first_shift <= 1'b0;
                end
                if (sample_edge) begin
                    shift_rx <= {shift_rx[W-2:0], mosi_s};
                    if (last_bit) begin
                        o_rx_data   <= {shift_rx[W-2:0], mosi_s};
                        o_rx_valid  <= 1'b1;
                        bit_cnt     <= '0;
                        reload_pend <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
